// File: rtl/pwm_pkg.sv
// Shared constants for the PWM block and anything that drives it.
// No logic; compile-time values only.
// No flow control; consumers pick the width up by import.
package pwm_pkg;

  // Default width of the duty and period fields.
  localparam int PWM_N = 8;

endpackage : pwm_pkg

// File: rtl/rising_edge_detect.sv
// One-clk pulse on each 0->1 transition of a level sampled on clk.
// Latency: pulse is combinational in the same clk the level is first seen high.
// No backpressure; every qualifying edge produces exactly one pulse.
module rising_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic in_q;

  // Remember last clk's level. Resetting to 1 means a level that is
  // already high when reset releases is not mistaken for a new edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q <= 1'b1;
    end else begin
      in_q <= in;
    end
  end

  assign pulse = in & ~in_q;

endmodule : rising_edge_detect

// File: rtl/pwm_generator.sv
// Tick-driven PWM: pwm_out high for duty ticks out of every period+1 ticks.
// Latency: pwm_out follows registered state; period_done is one clk after the wrap edge.
// No backpressure; ticks are consumed as they arrive, enable=0 idles and reloads.
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int N = PWM_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick_in,
  input  logic         enable,
  input  logic [N-1:0] duty,
  input  logic [N-1:0] period,
  output logic         pwm_out,
  output logic         period_done
);

  logic         tick;
  logic         wrap;

  logic [N-1:0] cnt_q,       cnt_d;
  logic [N-1:0] duty_sh_q,   duty_sh_d;
  logic [N-1:0] period_sh_q, period_sh_d;
  logic         enable_q;
  logic         period_done_q, period_done_d;

  // tick_in is a divided clock used purely as data; find its rising edges.
  rising_edge_detect u_tick_edge (
    .clk   (clk),
    .rst   (rst),
    .in    (tick_in),
    .pulse (tick)
  );

  // A wrap is the tick that ends the current period. cnt never exceeds
  // period_sh, so >= behaves as == but stays safe if that ever breaks.
  assign wrap = enable && tick && (cnt_q >= period_sh_q);

  // Next-state: idle reloads the shadows every clk; running only reloads
  // them at a wrap so mid-period duty/period changes wait for the boundary.
  always_comb begin
    cnt_d         = cnt_q;
    duty_sh_d     = duty_sh_q;
    period_sh_d   = period_sh_q;
    period_done_d = 1'b0;

    if (!enable) begin
      // Disable wins over any tick arriving in the same clk.
      cnt_d       = '0;
      duty_sh_d   = duty;
      period_sh_d = period;
    end else if (wrap) begin
      cnt_d         = '0;
      duty_sh_d     = duty;
      period_sh_d   = period;
      period_done_d = 1'b1;
    end else if (tick) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers; reset abandons any period in flight without a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      duty_sh_q     <= '0;
      period_sh_q   <= '0;
      enable_q      <= 1'b0;
      period_done_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      duty_sh_q     <= duty_sh_d;
      period_sh_q   <= period_sh_d;
      enable_q      <= enable;
      period_done_q <= period_done_d;
    end
  end

  // High while the position in the period is below the duty count.
  // duty_sh=0 never asserts; duty_sh>period_sh holds high the whole period.
  assign pwm_out     = enable_q && (cnt_q < duty_sh_q);
  assign period_done = period_done_q;

endmodule : pwm_generator

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator (N=4): directed scenarios with hand-counted
// expectations, then randomized stimulus against a tick-level model.
module tb_pwm_generator;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick_in;
  logic         enable;
  logic [N-1:0] duty;
  logic [N-1:0] period;
  logic         pwm_out;
  logic         period_done;

  pwm_generator #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_in     (tick_in),
    .enable      (enable),
    .duty        (duty),
    .period      (period),
    .pwm_out     (pwm_out),
    .period_done (period_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks ticks elapsed in the current period and the length of that period
  // in ticks (period+1); values latch at period boundaries or while idle.
  int pos, cur_duty, cur_len;
  bit last_lvl, running, pulse, is_tick;
  bit model_valid = 1'b0;
  bit exp_pwm, exp_pd;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      pos = 0; cur_duty = 0; cur_len = 1;
      last_lvl = 1'b1; running = 1'b0; pulse = 1'b0;
      model_valid = 1'b1;
    end else begin
      is_tick = tick_in && !last_lvl;
      pulse = 1'b0;
      if (!enable) begin
        pos = 0; cur_duty = int'(duty); cur_len = int'(period) + 1;
      end else if (is_tick) begin
        if (pos + 1 == cur_len) begin
          pos = 0; cur_duty = int'(duty); cur_len = int'(period) + 1;
          pulse = 1'b1;
        end else begin
          pos = pos + 1;
        end
      end
      last_lvl = tick_in;
      running  = enable;
    end
    exp_pwm = running && (pos < cur_duty);
    exp_pd  = pulse;
  end

  // Per-cycle compare against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (model_valid) begin
      check("pwm_out", int'(pwm_out), int'(exp_pwm));
      check("period_done", int'(period_done), int'(exp_pd));
    end
  end

  // ---------------- stimulus ----------------
  // tick_mode: 0 square wave (rising edge every 4 clks), 1 random, 2 high, 3 low
  int         tick_mode = 3;
  logic [1:0] sq = 2'd0;
  int         hi_cnt, pd_cnt;

  task automatic step();
    @(negedge clk);
    if (pwm_out) hi_cnt++;
    if (period_done) pd_cnt++;
    case (tick_mode)
      0: begin sq = sq + 2'd1; tick_in = sq[1]; end
      1: tick_in = 1'($urandom_range(0, 1));
      2: tick_in = 1'b1;
      default: tick_in = 1'b0;
    endcase
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic window(input int n);
    hi_cnt = 0; pd_cnt = 0;
    steps(n);
  endtask

  bit found;
  int h;

  initial begin
    rst = 1'b1; enable = 1'b0; duty = '0; period = '0; tick_in = 1'b0;
    steps(3);
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_pd", int'(period_done), 0);

    // Basic waveform: period=3, duty=1 -> 4 of 16 clks high, one pulse per 16.
    rst = 1'b0; duty = 4'd1; period = 4'd3; tick_mode = 0;
    steps(3);
    check("idle_pwm", int'(pwm_out), 0);
    enable = 1'b1;
    steps(8);
    window(64);
    check("basic_high", hi_cnt, 16);
    check("basic_pd", pd_cnt, 4);

    // Mid-period duty change 1->3 only applies from the next period.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (period_done) found = 1'b1;
    end
    check("wrap_seen", int'(found), 1);
    h = int'(pwm_out);
    hi_cnt = h; pd_cnt = 0;
    steps(6);
    duty = 4'd3;
    steps(9);
    check("mid_cur_high", hi_cnt, 4);
    window(16);
    check("mid_next_high", hi_cnt, 12);
    check("mid_next_pd", pd_cnt, 1);

    // duty=0 -> never high; then duty>period -> always high.
    duty = 4'd0;
    steps(20);
    window(64);
    check("duty0_high", hi_cnt, 0);
    duty = 4'd5;
    steps(20);
    window(64);
    check("dutybig_high", hi_cnt, 64);
    check("dutybig_pd", pd_cnt, 4);

    // period=0: every tick is a wrap.
    period = 4'd0; duty = 4'd1;
    steps(20);
    window(64);
    check("p0_high", hi_cnt, 64);
    check("p0_pd", pd_cnt, 16);

    // Disable mid-period: output drops one clk later, restart from cnt=0.
    period = 4'd3; duty = 4'd1;
    steps(22);
    enable = 1'b0;
    step();
    check("dis_pwm", int'(pwm_out), 0);
    check("dis_pd", int'(period_done), 0);
    duty = 4'd2;
    steps(3);
    enable = 1'b1;
    steps(40);

    // Reset for 2 clks with tick_in held high: nothing may fire afterwards.
    tick_mode = 2;
    steps(3);
    hi_cnt = 0; pd_cnt = 0;
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
    steps(8);
    check("rst_high", hi_cnt, 0);
    check("rst_pd", pd_cnt, 0);
    tick_mode = 0;
    steps(40);

    // Randomized phase, small N so boundaries (period=0, duty>period) are common.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) tick_mode = $urandom_range(0, 3);
      if ($urandom_range(0, 99) < 4) enable = ~enable;
      if ($urandom_range(0, 99) < 8) duty = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 8)
        period = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3))
                                             : 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    steps(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pwm_generator

// File: doc/pwm_generator.md
PWM_GENERATOR -- requirements
Module: pwm_generator

Interface
REQ-001 The module SHALL have parameter N, default 8, giving the width of the duty and period fields.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port tick_in, input, 1 bit: the clk_divided output of clock_divider, treated as a level sampled on clk and never used as a clock.
REQ-005 The module SHALL have port enable, input, 1 bit: 1 runs the PWM, 0 idles it.
REQ-006 The module SHALL have port duty, input, N bits: the number of ticks pwm_out is high per period.
REQ-007 The module SHALL have port period, input, N bits: the period length is period+1 ticks.
REQ-008 The module SHALL have port pwm_out, output, 1 bit: the PWM waveform.
REQ-009 The module SHALL have port period_done, output, 1 bit: a one-clk pulse per completed period.

Function
REQ-010 The module SHALL register tick_in into tick_q each clk; a tick is tick_in=1 && tick_q=0, one per rising edge of tick_in.
REQ-011 While enable=0: cnt SHALL be held at 0, duty_sh/period_sh SHALL reload from duty/period every clk, pwm_out SHALL be 0 and period_done SHALL be 0.
REQ-012 While enable=1, on a tick with cnt<period_sh, cnt SHALL increment by 1 at that clk edge.
REQ-013 While enable=1, on a tick with cnt==period_sh, cnt SHALL wrap to 0 and duty_sh/period_sh SHALL load duty/period at that same edge (wrap reload).
REQ-014 duty and period changes while enable=1 SHALL take effect only at the next wrap; mid-period changes SHALL NOT alter the current period.
REQ-015 pwm_out SHALL be combinational from registered state: enable_q && (cnt < duty_sh), where enable_q is enable registered one clk.
REQ-016 duty_sh=0 SHALL give pwm_out constantly 0; duty_sh>period_sh SHALL give pwm_out constantly 1 while running.
REQ-017 period_sh=0 SHALL make every tick a wrap; cnt stays 0.
REQ-018 period_done SHALL be a registered pulse, high for exactly one clk, in the clk after each wrap edge.
REQ-019 Without a tick, cnt, the shadows and period_done SHALL hold (period_done returns to 0).
REQ-020 A tick arriving in the same clk that enable falls SHALL be ignored; enable=0 takes priority.
REQ-021 All comparisons SHALL be unsigned N-bit; cnt SHALL never exceed period_sh.

Reset
REQ-022 rst=1 SHALL set cnt=0, tick_q=1, enable_q=0, duty_sh=0, period_sh=0 and period_done=0, so that pwm_out=0.
REQ-023 Reset SHALL take precedence over enable and ticks; tick_q=1 ensures tick_in already high at reset release is not counted as a tick.
REQ-024 Reset asserted mid-period SHALL abandon the period with no period_done pulse.

Structure
REQ-025 A shared package pwm_pkg SHALL hold the default width constant PWM_N=8; the parameter N SHALL default to it.
REQ-026 Tick edge detection SHALL be one sub-module, rising_edge_detect (ports clk, rst, in, pulse), reusable elsewhere.
REQ-027 The counter, shadows and output logic SHALL live in pwm_generator; the design SHALL be fully synchronous with no latches.

Verification
REQ-028 Test: N=4, period=3, duty=1, square-wave tick_in, enable=1 -> pwm_out high 1 tick of every 4; period_done pulses once per 4 ticks.
REQ-029 Test: duty=0, then duty=5 with period=3 -> pwm_out constantly 0, then constantly 1 from the next wrap.
REQ-030 Test: change duty 1->3 mid-period -> the current period keeps 1 high tick; the following period has 3.
REQ-031 Test: period=0, duty=1 -> pwm_out stays 1 and period_done pulses after every tick.
REQ-032 Test: deassert enable mid-period, then reassert -> pwm_out=0 within 1 clk; restart from cnt=0 with current inputs.
REQ-033 Test: assert rst for 2 clks mid-period with tick_in high -> all outputs 0, no spurious period_done, no extra tick at release.
